vfpu_sequencer: RTL

Job sequencer for the vector-FPU HWPE. It latches one job from the register file (two operand base addresses, one result base address, element count and opcode) and clears the streamer. It then launches the two load streams and the store stream together, counts result elements accepted into the store path, and waits for the store stream to finish. It finishes with a one-cycle done pulse and per-core events. It sits between the register-file/control slave and the streamer, taking the place of the hand-written start logic in the control block.

---
 rtl/vfpu_sequencer_if.sv | 36 +++
 rtl/vfpu_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/vfpu_sequencer_if.sv
// Streamer-side bundle of the vector-FPU job sequencer.
// Handshake semantics: every *_req_start_o is a request that the streamer
// takes in the same cycle it is high; the sequencer only raises it while the
// matching *_ready_start_i is already high, so request implies acceptance.
// The result stream transfers one element on each clock where
// res_valid_i & res_ready_i are both high; the sequencer only observes it.
interface vfpu_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic                       clear_o;
    logic [1:0]                 src_req_start_o;
    logic [1:0]                 src_ready_start_i;
    logic [1:0][ADDR_WIDTH-1:0] src_addr_o;
    logic                       sink_req_start_o;
    logic                       sink_ready_start_i;
    logic [ADDR_WIDTH-1:0]      sink_addr_o;
    logic [LEN_WIDTH-1:0]       trans_size_o;
    logic                       res_valid_i;
    logic                       res_ready_i;
    logic                       sink_done_i;

    modport master (
        output clear_o, src_req_start_o, src_addr_o, sink_req_start_o,
               sink_addr_o, trans_size_o,
        input  src_ready_start_i, sink_ready_start_i, res_valid_i,
               res_ready_i, sink_done_i
    );

    modport slave (
        input  clear_o, src_req_start_o, src_addr_o, sink_req_start_o,
               sink_addr_o, trans_size_o,
        output src_ready_start_i, sink_ready_start_i, res_valid_i,
               res_ready_i, sink_done_i
    );
endinterface

// File: rtl/vfpu_sequencer.sv
// Job sequencer for the vector-FPU HWPE: latches a job, clears the streamer,
// starts both load streams and the store stream together, counts accepted
// results, waits for the store stream to drain and signals completion.
module vfpu_sequencer #(
    parameter int N_CORES    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_c_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [1:0]            op_i,
    output logic [1:0]            op_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [N_CORES-1:0]    evt_o,
    output logic [2:0]            state_o,
    vfpu_sequencer_if.master      strm
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CLEAR      = 3'd1,
        S_START      = 3'd2,
        S_RUN        = 3'd3,
        S_WAIT_STORE = 3'd4,
        S_DONE       = 3'd5
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr_a;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [ADDR_WIDTH-1:0] r_addr_c;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [1:0]            r_op;

    logic w_accept;
    logic w_zero_job;
    logic w_ready_all;
    logic w_hs;
    logic w_last;

    // Only an idle sequencer looks at start_i; zero-length jobs skip the streamer.
    assign w_accept    = (r_state == S_IDLE) && start_i && (len_i != '0);
    assign w_zero_job  = (r_state == S_IDLE) && start_i && (len_i == '0);
    assign w_ready_all = (strm.src_ready_start_i == 2'b11) && strm.sink_ready_start_i;
    assign w_hs        = strm.res_valid_i && strm.res_ready_i;
    assign w_last      = w_hs && (r_cnt == r_len - LEN_WIDTH'(1));

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Job latch: captured once per accepted start, held until the next one.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_addr_c <= '0;
            r_len    <= '0;
            r_op     <= '0;
        end else if (w_accept) begin
            r_addr_a <= addr_a_i;
            r_addr_b <= addr_b_i;
            r_addr_c <= addr_c_i;
            r_len    <= len_i;
            r_op     <= op_i;
        end
    end

    // Result counter: only RUN counts, and RUN is left on the last element so it never wraps.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == S_RUN) && w_hs) begin
            r_cnt <= r_cnt + LEN_WIDTH'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_CLEAR;
                end else if (w_zero_job) begin
                    w_state_next = S_DONE;
                end
            end
            S_CLEAR:      w_state_next = S_START;
            S_START:      if (w_ready_all) w_state_next = S_RUN;
            S_RUN:        if (w_last) w_state_next = S_WAIT_STORE;
            S_WAIT_STORE: if (strm.sink_done_i) w_state_next = S_DONE;
            S_DONE:       w_state_next = S_IDLE;
            default:      w_state_next = S_IDLE;
        endcase
    end

    // Outputs: pulses decoded from state, stream requests gated by all three readies.
    always_comb begin
        strm.clear_o          = 1'b0;
        strm.src_req_start_o  = 2'b00;
        strm.sink_req_start_o = 1'b0;
        done_o                = 1'b0;
        evt_o                 = '0;
        busy_o                = (r_state != S_IDLE);
        strm.src_addr_o       = {r_addr_b, r_addr_a};
        strm.sink_addr_o      = r_addr_c;
        strm.trans_size_o     = r_len;
        op_o                  = r_op;
        state_o               = r_state;
        case (r_state)
            S_CLEAR: strm.clear_o = 1'b1;
            S_START: begin
                if (w_ready_all) begin
                    strm.src_req_start_o  = 2'b11;
                    strm.sink_req_start_o = 1'b1;
                end
            end
            S_DONE: begin
                done_o = 1'b1;
                evt_o  = {N_CORES{1'b1}};
            end
            default: ;
        endcase
    end

endmodule
